// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM with byte-lane stores, one-entry store buffer with load forwarding,
// and a post-reset clear sequence that zeroes the array before reporting ready.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_mem_in,
   input  logic        d_mem_wen,
   input  logic [1:0]  write_data_size,
   output logic [31:0] d_mem_out,
   output logic        misaligned,
   output logic        ready
);
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_next;
   logic [31:0] mem [DEPTH_WORDS];
   logic [IDX_W-1:0] clr_cnt, idx, sb_idx;
   logic [3:0] mask, sb_mask;
   logic [31:0] data, sb_data;
   logic [1:0] l;
   logic sb_valid, aligned, accept, drop, unused;
   assign idx = d_addr[IDX_W+1:2];
   assign l = d_addr[1:0];
   assign unused = ^d_addr[31:IDX_W+2];
   assign ready = state == RUN;
   always_comb begin
      state_next = state;
      if (state == CLEAR && &clr_cnt) state_next = RUN;
   end
   always_comb begin
      mask = write_data_size == 2'd3 ? 4'hf : write_data_size == 2'd2 ? 4'b0011 << l : 4'b0001 << l;
      data = write_data_size == 2'd3 ? d_mem_in : write_data_size == 2'd2 ? {2{d_mem_in[15:0]}} : {4{d_mem_in[7:0]}};
      aligned = write_data_size == 2'd3 ? l == 2'd0 : write_data_size == 2'd2 ? !l[0] : 1'b1;
      accept = ready && d_mem_wen && write_data_size != 2'd0 && aligned;
      drop = ready && d_mem_wen && write_data_size != 2'd0 && !aligned;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         clr_cnt <= '0;
         sb_valid <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state <= state_next;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         sb_valid <= accept;
         misaligned <= drop;
         if (accept) begin
            sb_idx <= idx;
            sb_mask <= mask;
            sb_data <= data;
         end
      end
   end
   // The array itself is never reset; the clear sequence zeroes it and a reset drops the buffered store uncommitted.
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) mem[clr_cnt] <= '0;
      else if (!rst && sb_valid)
         for (int k = 0; k < 4; k++)
            if (sb_mask[k]) mem[sb_idx][8*k +: 8] <= sb_data[8*k +: 8];
   end
   always_comb begin
      d_mem_out = '0;
      if (ready)
         for (int k = 0; k < 4; k++)
            d_mem_out[8*k +: 8] = (sb_valid && sb_idx == idx && sb_mask[k]) ? sb_data[8*k +: 8] : mem[idx][8*k +: 8];
   end
endmodule
